// File: rtl/img_sort_pkg.sv
// Shared types for the image sorting datapath: channel codes, stored pixel record, sorter FSM states.
// The helper picks the first drain state for a mask of non-empty bins, in R, G, B priority.
package img_sort_pkg;
   localparam int IDX_W = 12;
   localparam int DEPTH = 16;

   localparam logic [1:0] CH_R = 2'd0;
   localparam logic [1:0] CH_G = 2'd1;
   localparam logic [1:0] CH_B = 2'd2;

   typedef struct packed {
      logic [7:0]       intensity;
      logic [IDX_W-1:0] index;
   } pix_rec_t;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      DRAIN_R = 2'd1,
      DRAIN_G = 2'd2,
      DRAIN_B = 2'd3
   } state_t;

   function automatic state_t first_drain(input logic [2:0] mask);
      if (mask[0])      return DRAIN_R;
      else if (mask[1]) return DRAIN_G;
      else if (mask[2]) return DRAIN_B;
      else              return FILL;
   endfunction
endpackage

// File: rtl/pixel_bin_sorter_if.sv
// Classified-pixel input stream, sorted-record output stream and sorter status flags.
interface pixel_bin_sorter_if;
   import img_sort_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_sel;
   logic [7:0]       in_intensity;
   logic [IDX_W-1:0] in_index;
   logic             in_last;

   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_chan;
   logic [7:0]       out_intensity;
   logic [IDX_W-1:0] out_index;
   logic             out_last;

   logic             frame_done;
   logic             overflow;
   logic             sel_err;

   modport master (
      output in_valid, in_sel, in_intensity, in_index, in_last, out_ready,
      input  in_ready, out_valid, out_chan, out_intensity, out_index, out_last,
             frame_done, overflow, sel_err
   );

   modport slave (
      input  in_valid, in_sel, in_intensity, in_index, in_last, out_ready,
      output in_ready, out_valid, out_chan, out_intensity, out_index, out_last,
             frame_done, overflow, sel_err
   );
endinterface

// File: rtl/sort_bin.sv
// One channel bin: linear write count and read pointer over a DEPTH-entry array; zero-latency read port.
// Writes to a full bin are ignored; the caller flags the drop. clear rewinds both pointers synchronously.
module sort_bin #(
   parameter int DEPTH = 16,
   parameter int W     = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         wr_en,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_en,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty,
   output logic         last
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  count;
   logic [AW:0]  rd_ptr;

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign last   = ((rd_ptr + 1'b1) == count);
   assign rd_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         count  <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            count <= count + 1'b1;
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Payload storage needs no reset: count/rd_ptr gate every read.
   always_ff @(posedge clk) begin
      if (wr_en && !full)
         mem[count[AW-1:0]] <= wr_dat;
   end
endmodule

// File: rtl/pixel_bin_sorter.sv
// Files classified pixels into R/G/B bins, then drains R, G, B at 1 record/cycle starting the cycle after in_last.
// Input is always ready while filling and never while draining; output records hold steady under out_ready=0.
module pixel_bin_sorter
   import img_sort_pkg::*;
#(
   parameter int DEPTH = img_sort_pkg::DEPTH
) (
   input logic               clk,
   input logic               rst_n,
   pixel_bin_sorter_if.slave bus
);
   state_t     state, state_nxt;
   logic [2:0] wr_en, rd_en, full, empty, last;
   logic [1:0] cur;
   logic [2:0] later;
   logic       sel_ok, accept, hs, clear, done_nxt;
   logic       frame_done_q, overflow_q, sel_err_q;
   pix_rec_t   wr_rec, out_rec;
   pix_rec_t   rd_rec [3];

   assign sel_ok = (bus.in_sel == 3'b001) || (bus.in_sel == 3'b010) || (bus.in_sel == 3'b100);
   assign accept = bus.in_valid && (state == FILL);
   assign hs     = bus.out_valid && bus.out_ready;
   assign wr_en  = (accept && sel_ok) ? (bus.in_sel & ~full) : 3'b000;
   assign wr_rec = '{intensity: bus.in_intensity, index: bus.in_index};

   for (genvar g = 0; g < 3; g++) begin : g_bin
      sort_bin #(.DEPTH(DEPTH), .W($bits(pix_rec_t))) u_bin (
         .clk    (clk),
         .rst_n  (rst_n),
         .clear  (clear),
         .wr_en  (wr_en[g]),
         .wr_dat (wr_rec),
         .rd_en  (rd_en[g]),
         .rd_dat (rd_rec[g]),
         .full   (full[g]),
         .empty  (empty[g]),
         .last   (last[g])
      );
   end

   // Channel being drained and the bins still waiting behind it.
   assign cur   = (state == DRAIN_G) ? CH_G : (state == DRAIN_B) ? CH_B : CH_R;
   assign later = (state == DRAIN_R) ? {~empty[2], ~empty[1], 1'b0} :
                  (state == DRAIN_G) ? {~empty[2], 2'b00} : 3'b000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      done_nxt  = 1'b0;
      if (state == FILL) begin
         // The closing beat's own write counts towards which bins are non-empty.
         if (accept && bus.in_last) begin
            state_nxt = first_drain(~empty | wr_en);
            done_nxt  = (first_drain(~empty | wr_en) == FILL);
         end
      end else if (hs && last[cur]) begin
         state_nxt = first_drain(later);
         if (later == 3'b000) begin
            clear    = 1'b1;
            done_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      out_rec           = (cur == CH_G) ? rd_rec[1] : (cur == CH_B) ? rd_rec[2] : rd_rec[0];
      bus.in_ready      = (state == FILL);
      bus.out_valid     = (state != FILL);
      bus.out_chan      = cur;
      bus.out_intensity = out_rec.intensity;
      bus.out_index     = out_rec.index;
      bus.out_last      = (state != FILL) && last[cur] && (later == 3'b000);
      rd_en             = hs ? (3'b001 << cur) : 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         frame_done_q <= done_nxt;
         if (accept && sel_ok && ((bus.in_sel & full) != 3'b000))
            overflow_q <= 1'b1;
         if (accept && !sel_ok)
            sel_err_q <= 1'b1;
      end
   end

   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
   assign bus.sel_err    = sel_err_q;
endmodule

// File: tb/tb_pixel_bin_sorter.sv
// Bench for pixel_bin_sorter: per-frame channel-grouping model from queued beats, random and directed frames.
`timescale 1ns/1ps
module tb_pixel_bin_sorter;
   import img_sort_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pixel_bin_sorter_if bus();
   pixel_bin_sorter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;
   bit m_ovf = 1'b0;
   bit m_serr = 1'b0;

   logic [2:0]       b_sel[$];
   logic [7:0]       b_int[$];
   logic [IDX_W-1:0] b_idx[$];

   task automatic clear_beats();
      b_sel.delete(); b_int.delete(); b_idx.delete();
   endtask

   task automatic push_beat(input logic [2:0] sel, input int idx);
      b_sel.push_back(sel);
      b_int.push_back(8'($urandom));
      b_idx.push_back(IDX_W'(idx));
   endtask

   // Drive the queued frame, then drain and compare against the grouped expectation.
   // abort_at >= 0 asserts reset when that record is presented.
   task automatic run_frame(input string nm, input int pct, input int hold_at, input int abort_at);
      int               e_ch[$];
      logic [7:0]       e_int[$];
      logic [IDX_W-1:0] e_idx[$];
      int               taken, k, n, hold, budget;
      bit               rdy;
      for (int i = 0; i < b_sel.size(); i++)
         if (!$onehot(b_sel[i])) m_serr = 1'b1;
      for (int c = 0; c < 3; c++) begin
         taken = 0;
         for (int i = 0; i < b_sel.size(); i++) begin
            if (b_sel[i] == 3'(1 << c)) begin
               if (taken < DEPTH) begin
                  e_ch.push_back(c); e_int.push_back(b_int[i]); e_idx.push_back(b_idx[i]);
                  taken++;
               end else m_ovf = 1'b1;
            end
         end
      end

      for (int i = 0; i < b_sel.size(); i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1; bus.in_sel = b_sel[i]; bus.in_intensity = b_int[i];
         bus.in_index = b_idx[i]; bus.in_last = (i == b_sel.size() - 1);
         tests++;
         if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready beat %0d: got %b want 1", nm, i, bus.in_ready);
         end
         @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;

      n = e_ch.size(); k = 0; hold = 0; budget = 0;
      while (1) begin
         if (k == n) begin
            tests++;
            if (bus.frame_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
               fails++;
               $display("FAIL %s frame_end: got done=%b valid=%b in_ready=%b want 1 0 1",
                        nm, bus.frame_done, bus.out_valid, bus.in_ready);
            end
            break;
         end
         tests++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.frame_done !== 1'b0 ||
             bus.out_chan !== 2'(e_ch[k]) || bus.out_intensity !== e_int[k] ||
             bus.out_index !== e_idx[k] || bus.out_last !== (k == n - 1)) begin
            fails++;
            $display("FAIL %s rec %0d: got v=%b rdy=%b done=%b ch=%0d int=%0d idx=%0d last=%b want v=1 rdy=0 done=0 ch=%0d int=%0d idx=%0d last=%b",
                     nm, k, bus.out_valid, bus.in_ready, bus.frame_done, bus.out_chan, bus.out_intensity,
                     bus.out_index, bus.out_last, e_ch[k], e_int[k], e_idx[k], (k == n - 1));
         end
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            tests++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_last !== 1'b0 ||
                bus.overflow !== 1'b0 || bus.sel_err !== 1'b0) begin
               fails++;
               $display("FAIL %s async_reset: got v=%b rdy=%b last=%b ovf=%b serr=%b want 0 1 0 0 0",
                        nm, bus.out_valid, bus.in_ready, bus.out_last, bus.overflow, bus.sel_err);
            end
            @(negedge clk);
            rst_n = 1'b1;
            m_ovf = 1'b0; m_serr = 1'b0;
            clear_beats();
            return;
         end
         rdy = ($urandom_range(0, 99) < pct);
         if (k == hold_at && hold < 5) begin
            rdy = 1'b0;
            hold++;
         end
         bus.out_ready = rdy;
         @(posedge clk);
         if (rdy) k++;
         @(negedge clk);
         budget++;
         if (budget > 2000) begin
            tests++; fails++;
            $display("FAIL %s drain_timeout: got %0d records want %0d", nm, k, n);
            break;
         end
      end
      bus.out_ready = 1'b0;
      tests++;
      if (bus.overflow !== m_ovf || bus.sel_err !== m_serr) begin
         fails++;
         $display("FAIL %s flags: got ovf=%b serr=%b want ovf=%b serr=%b",
                  nm, bus.overflow, bus.sel_err, m_ovf, m_serr);
      end
      clear_beats();
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_sel = 3'b000; bus.in_intensity = '0;
      bus.in_index = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (bus.in_ready !== 1'b1)   begin fails++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
      tests++; if (bus.out_valid !== 1'b0)  begin fails++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
      tests++; if (bus.out_last !== 1'b0)   begin fails++; $display("FAIL reset out_last: got %b want 0", bus.out_last); end
      tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset frame_done: got %b want 0", bus.frame_done); end
      tests++; if (bus.overflow !== 1'b0)   begin fails++; $display("FAIL reset overflow: got %b want 0", bus.overflow); end
      tests++; if (bus.sel_err !== 1'b0)    begin fails++; $display("FAIL reset sel_err: got %b want 0", bus.sel_err); end
      rst_n = 1'b1;
      m_ovf = 1'b0; m_serr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      push_beat(3'b001, 0); push_beat(3'b010, 1); push_beat(3'b100, 2); push_beat(3'b010, 3);
      run_frame("basic", 100, -1, -1);
   endtask

   task automatic test_only_b();
      for (int i = 0; i < 3; i++) push_beat(3'b100, 10 + i);
      run_frame("only_b", 100, -1, -1);
   endtask

   task automatic test_backpressure();
      push_beat(3'b010, 0); push_beat(3'b001, 1); push_beat(3'b100, 2);
      push_beat(3'b001, 3); push_beat(3'b010, 4); push_beat(3'b100, 5);
      run_frame("backpressure", 100, 2, -1);
   endtask

   task automatic test_reset_mid_drain();
      push_beat(3'b001, 0); push_beat(3'b010, 1); push_beat(3'b001, 2);
      push_beat(3'b010, 3); push_beat(3'b100, 4); push_beat(3'b010, 5);
      run_frame("mid_drain_abort", 100, -1, 3);
      push_beat(3'b100, 7); push_beat(3'b010, 8); push_beat(3'b010, 9);
      run_frame("after_reset", 100, -1, -1);
   endtask

   task automatic test_sel_err();
      push_beat(3'b001, 0); push_beat(3'b100, 1); push_beat(3'b011, 2);
      push_beat(3'b010, 3); push_beat(3'b001, 4);
      run_frame("sel_err", 100, -1, -1);
   endtask

   task automatic test_empty_frame();
      push_beat(3'b000, 0);
      run_frame("empty_frame", 100, -1, -1);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH + 1; i++) push_beat(3'b001, i);
      run_frame("overflow", 100, -1, -1);
   endtask

   task automatic test_random();
      logic [2:0] s;
      for (int f = 0; f < 10; f++) begin
         for (int i = 0; i < $urandom_range(1, 40); i++) begin
            s = ($urandom_range(0, 99) < 85) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            push_beat(s, i);
         end
         run_frame("random", $urandom_range(30, 100), -1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_only_b();
      test_backpressure();
      test_reset_mid_drain();
      test_sel_err();
      test_empty_frame();
      test_overflow();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
